// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// flags, and a choice of registered or first-word-fall-through read output.
//
// Handshake: en_in is a write request that is taken on a rising edge when
// the FIFO is not full, or when it is full but a read is taken on the same
// edge. en_out is a read request that is taken on a rising edge only when
// the FIFO is not empty. A request that is not taken changes no state
// except the sticky error flags. There is no back-pressure output besides
// full/empty; the producer and consumer watch those.
module fifo_param #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_in,
    input  logic [WIDTH-1:0]         in,
    input  logic                     en_out,
    output logic [WIDTH-1:0]         out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic wr_ok;
    logic rd_ok;

    // Flags are pure decodes of the registered count, so they move on the
    // same edge as the count itself.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions and next-state values for pointers, count and errors.
    always_comb begin
        wr_ok       = en_in && (!full || en_out);
        rd_ok       = en_out && !empty;
        wr_ptr_d    = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d    = rd_ptr_q + AW'(rd_ok);
        count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
        overflow_d  = overflow_q || (en_in && full && !en_out);
        underflow_d = underflow_q || (en_out && empty);
    end

    // Control state: pointers, occupancy and the sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; not cleared by reset since an empty FIFO hides it.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr_q] <= in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; zero while nothing is stored.
        assign out = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_reg
        logic [WIDTH-1:0] out_q;

        // Registered read port: loads the head word only on an accepted read.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
            end else if (rd_ok) begin
                out_q <= mem[rd_ptr_q];
            end
        end

        assign out = out_q;
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed bench for fifo_param. Two instances share the
// stimulus: u_reg (registered read) and u_fwft (first-word-fall-through).
// Expected read words for u_reg go into a queue when a read is issued; a
// monitor branch pops and compares one cycle after each expected read.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_in = 1'b0;
    logic [3:0] din = 4'h0;
    logic       en_out = 1'b0;
    logic       exp_rd = 1'b0;

    logic [3:0] out0, out1;
    logic       empty0, full0, af0, ae0, ovf0, unf0;
    logic       empty1, full1, af1, ae1, ovf1, unf1;
    logic [3:0] count0, count1;

    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    fifo_param #(.WIDTH(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .en_in(en_in), .in(din), .en_out(en_out),
        .out(out0), .empty(empty0), .full(full0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    fifo_param #(.WIDTH(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .en_in(en_in), .in(din), .en_out(en_out),
        .out(out1), .empty(empty1), .full(full1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog: the directed flow is short; anything this long is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle; inputs change at posedge+1, away from the edge.
    // rd_ok_exp marks a read that must be accepted by u_reg, with its data.
    task automatic drv(input logic wi, input logic [3:0] d, input logic ro,
                       input logic rd_ok_exp, input logic [3:0] rd_data);
        en_in  = wi;
        din    = d;
        en_out = ro;
        exp_rd = rd_ok_exp;
        if (rd_ok_exp) exp_q.push_back(rd_data);
        @(posedge clk);
        #1;
        en_in  = 1'b0;
        en_out = 1'b0;
        exp_rd = 1'b0;
    endtask

    task automatic wr(input logic [3:0] d);
        drv(1'b1, d, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic rd(input logic [3:0] e);
        drv(1'b0, 4'h0, 1'b1, 1'b1, e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, int'(count0), 0);
        chk({tag, "_empty"}, int'(empty0), 1);
        chk({tag, "_full"}, int'(full0), 0);
        chk({tag, "_ae"}, int'(ae0), 1);
        chk({tag, "_af"}, int'(af0), 0);
        chk({tag, "_ovf"}, int'(ovf0), 0);
        chk({tag, "_unf"}, int'(unf0), 0);
        chk({tag, "_out"}, int'(out0), 0);
        chk({tag, "_out_fwft"}, int'(out1), 0);
        chk({tag, "_count_fwft"}, int'(count1), 0);
    endtask

    logic [3:0] fill_a[8];
    logic [3:0] exp_w;
    logic       mon_v;

    initial begin
        fill_a = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'h2, 4'h7};

        fork
            // Monitor: one cycle after an expected read, compare u_reg.out.
            forever begin
                @(posedge clk);
                mon_v = exp_rd && !rst;
                @(negedge clk);
                if (mon_v) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rd_data: got %0h expected <no queued word>", out0);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (out0 !== exp_w) begin
                            n_fail++;
                            $display("FAIL rd_data: got %0h expected %0h", out0, exp_w);
                        end
                    end
                end
            end
        join_none

        // Reset held for two cycles
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_reset_state("rst");
        rst = 1'b0;

        // Fill 2,3,5 with almost_empty boundary at count 2 -> 3
        wr(4'h2);
        wr(4'h3);
        chk("ae_at_2", int'(ae0), 1);
        wr(4'h5);
        chk("fill_count", int'(count0), 3);
        chk("fill_empty", int'(empty0), 0);
        chk("fill_ae", int'(ae0), 0);

        // Ordered read
        rd(4'h2);
        rd(4'h3);
        rd(4'h5);
        chk("drain_count", int'(count0), 0);
        chk("drain_empty", int'(empty0), 1);

        // Fill to full and overflow
        for (int i = 0; i < 8; i++) begin
            wr(fill_a[i]);
            if (i == 4) chk("af_at_5", int'(af0), 0);
            if (i == 5) begin
                chk("af_at_6", int'(af0), 1);
                chk("count_6", int'(count0), 6);
            end
            if (i == 6) chk("full_at_7", int'(full0), 0);
        end
        chk("full_at_8", int'(full0), 1);
        chk("count_8", int'(count0), 8);
        chk("ovf_before", int'(ovf0), 0);
        wr(4'hA);
        chk("ovf_count", int'(count0), 8);
        chk("ovf_set", int'(ovf0), 1);
        for (int i = 0; i < 8; i++) rd(fill_a[i]);
        chk("wrap_empty", int'(empty0), 1);
        chk("ovf_sticky", int'(ovf0), 1);

        // Underflow, then simultaneous read+write on empty
        chk("unf_before", int'(unf0), 0);
        drv(1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
        chk("unf_set", int'(unf0), 1);
        chk("unf_count", int'(count0), 0);
        drv(1'b1, 4'h6, 1'b1, 1'b0, 4'h0);
        chk("rw_empty_count", int'(count0), 1);
        chk("rw_empty_unf", int'(unf0), 1);
        rd(4'h6);
        chk("rw_empty_drain", int'(count0), 0);

        // Full simultaneous read+write (fresh reset clears sticky flags)
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_ovf", int'(ovf0), 0);
        for (int i = 0; i < 8; i++) wr(4'(i));
        drv(1'b1, 4'hF, 1'b1, 1'b1, 4'h0);
        chk("rw_full_full", int'(full0), 1);
        chk("rw_full_count", int'(count0), 8);
        chk("rw_full_ovf", int'(ovf0), 0);
        for (int i = 1; i < 8; i++) rd(4'(i));
        rd(4'hF);
        chk("rw_full_empty", int'(empty0), 1);

        // FWFT behaviour
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("fwft_out_empty", int'(out1), 0);
        wr(4'h3);
        chk("fwft_head", int'(out1), 3);
        chk("fwft_empty", int'(empty1), 0);
        wr(4'h9);
        chk("fwft_hold", int'(out1), 3);
        rd(4'h3);
        chk("fwft_adv", int'(out1), 9);
        chk("fwft_count", int'(count1), 1);
        wr(4'h5);

        // Mid-stream reset with a write pending
        rst = 1'b1;
        drv(1'b1, 4'hC, 1'b0, 1'b0, 4'h0);
        chk_reset_state("mid_rst");
        chk("mid_rst_empty_fwft", int'(empty1), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        chk("sb_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the lab-3 4-bit register-file FIFO. It generalises data width and depth and adds an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. It also offers a selectable read mode: registered output, or first-word-fall-through (FWFT). It sits between producer and consumer stages of the lab datapath, one clock domain.

## Interface
- WIDTH, 4, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AFULL_TH, 6, almost_full asserted when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserted when count ≤ AEMPTY_TH (0..DEPTH-1)
- FWFT, 0, 0 = registered read output; 1 = first-word-fall-through
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- en_in  in  1  write request
- in  in  WIDTH  write data
- en_out  in  1  read request
- out  out  WIDTH  read data
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full and not accepted
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Storage: DEPTH × WIDTH array; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally; count is tracked separately.
- Write accepted (wr_ok) when en_in && (!full || en_out). A write while full with en_out also asserted is accepted, because the read frees the slot in the same cycle.
- Read accepted (rd_ok) when en_out && !empty. A read while empty is never accepted, even with a simultaneous write.
- On each edge:
  - wr_ok: mem[wr_ptr] ← in, and wr_ptr increments.
  - rd_ok: rd_ptr increments.
  - count ← count + wr_ok − rd_ok.
- overflow ← 1 on en_in && full && !en_out.
- underflow ← 1 on en_out && empty. It is set even when a simultaneous write is accepted that cycle.
- overflow and underflow stay set until rst.
- A rejected operation changes no pointer, count, memory or out value.
- empty, full, almost_full and almost_empty are combinational decodes of the registered count.
- FWFT=0: out is a register.
  - On rd_ok, out ← mem[rd_ptr], visible after the edge.
  - Otherwise out holds its value.
- FWFT=1: out = mem[rd_ptr] when !empty, and 0 when empty. The head word is visible without a read; rd_ok advances to the next word.
- Reset (rst=1 at an edge) returns to the reset state regardless of en_in/en_out, including mid-stream:
  - wr_ptr = rd_ptr = 0, count = 0;
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0;
  - overflow = underflow = 0, out = 0.
- Memory contents are not cleared by rst; they are unobservable because the FIFO is empty.

## Timing
- Write-to-visible latency:
  - FWFT=1: a word written into an empty FIFO at edge N appears on out after edge N; empty falls after edge N.
  - FWFT=0: the first read may be issued in the cycle after edge N; data appears on out after that read's edge.
- Read latency, FWFT=0: one cycle from an accepted en_out to data on out.
- Flags and count update together after the same edge as the operation that changed them. There is no extra flag latency.
- Simultaneous read+write:
  - 0 < count < DEPTH: count unchanged, both pointers advance.
  - At full: both accepted, full stays 1.
  - At empty: write only, count → 1, underflow set.
- While rst is held, all outputs stay at their reset values.

## Test plan
- **Reset and fill** (defaults). Hold rst 2 cycles, then write 2,3,5 on three edges.
  - After reset: empty=1, count=0, out=0.
  - After the writes: count=3, empty=0, almost_empty=0.
- **Ordered read, FWFT=0.** After the fill above, assert en_out for 3 cycles.
  - out = 2, 3, 5 on successive cycles.
  - count reaches 0; empty=1 after the third read.
- **Fill to full and overflow.** Write 1,2,3,4,8,9,2,7.
  - almost_full=1 at count=6; full=1 at count=8.
  - A ninth write of 4'hA leaves count=8 and sets overflow=1.
  - Subsequent reads return 1,2,3,4,8,9,2,7, confirming pointer wrap and that A was dropped.
- **Underflow and empty simultaneous read+write.** On an empty FIFO, assert en_out alone, then en_out+en_in with in=6.
  - First cycle: underflow=1, count=0.
  - Second cycle: count=1, and a later read returns 6.
- **Full simultaneous read+write.** At count=8, en_in=1 (in=F) with en_out=1.
  - The oldest word is read, full remains 1, overflow is not set.
  - After draining, F is the last word.
- **FWFT=1 and mid-stream reset.**
  - Write 3: out=3 right after the write edge with no read. en_out advances out to the next word.
  - Assert rst with en_in=1 mid-stream: count=0, out=0, and flags return to reset values on that edge.
